// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and coordinate type for the VGA output path.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

    // Wide enough for H_TOTAL-1 and V_TOTAL-1.
    localparam int CW       = 10;

    typedef logic [CW-1:0] coord_t;

endpackage

// File: rtl/vga_wrap_counter.sv
// Enable-gated counter that wraps from MAX to 0. It resets to MAX so the first
// enable lands on 0. The next value is exported so the parent can register
// decodes that line up with the new count.
module vga_wrap_counter
    import vga_pkg::*;
#(
    parameter int W   = CW,
    parameter int MAX = H_TOTAL - 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt_nxt,
    output logic         tc
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt;

    assign tc = (cnt == MAX_V);

    // Next count: hold when disabled, wrap at the terminal count, else increment.
    always_comb begin
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = tc ? '0 : cnt + W'(1);
        end
    end

    // Count register, parked at MAX while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= MAX_V;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel timing generator. It runs on the system clock and advances on pix_en.
// All outputs are registered from the next counter values, so sync, video_on and
// the strobes stay aligned with pix_x/pix_y.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = vga_pkg::CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_tc;
    logic          v_tc;
    logic          v_en;

    // The line counter steps only on the pixel that ends a line.
    assign v_en = pix_en & h_tc;

    vga_wrap_counter #(.W(CW), .MAX(H_TOTAL - 1)) u_h_cnt (
        .clk     (clk),
        .reset   (reset),
        .en      (pix_en),
        .cnt_nxt (h_nxt),
        .tc      (h_tc)
    );

    vga_wrap_counter #(.W(CW), .MAX(V_TOTAL - 1)) u_v_cnt (
        .clk     (clk),
        .reset   (reset),
        .en      (v_en),
        .cnt_nxt (v_nxt),
        .tc      (v_tc)
    );

    // Register the decoded timing from the next counts; strobes last one clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_sync      <= ~SYNC_POL;
            v_sync      <= ~SYNC_POL;
            video_on    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                pix_x       <= h_nxt;
                pix_y       <= v_nxt;
                video_on    <= (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
                h_sync      <= ((h_nxt >= HS_BEG) && (h_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
                v_sync      <= ((v_nxt >= VS_BEG) && (v_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
            end
        end
    end

    // The v terminal count is implied by v_nxt wrapping; keep it for debug visibility.
    logic unused_v_tc;
    assign unused_v_tc = v_tc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance and a tiny-timing
// instance (active-high syncs) share clock, reset and pix_en. A reference model
// pushes expected outputs when each step is driven; they are popped after the edge.
module tb_vga_timing_gen;
    import vga_pkg::*;

    // Small timing for the second instance so whole frames fit in a short run.
    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 3;
    localparam int S_VA = 6, S_VF = 2, S_VS = 2, S_VB = 2;
    localparam bit S_POL = 1'b1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;  // 16
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;  // 12
    localparam int OW = 25;  // {h_sync, v_sync, video_on, line_start, frame_start, x[9:0], y[9:0]}

    logic clk, reset, pix_en;
    logic d_h_sync, d_v_sync, d_video_on, d_line_start, d_frame_start;
    logic s_h_sync, s_v_sync, s_video_on, s_line_start, s_frame_start;
    logic [CW-1:0] d_pix_x, d_pix_y, s_pix_x, s_pix_y;

    int dh, dv, sh, sv;
    logic [OW-1:0] d_exp, s_exp, d_obs, s_obs;
    logic [2*OW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    vga_timing_gen dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .h_sync(d_h_sync), .v_sync(d_v_sync), .video_on(d_video_on),
        .pix_x(d_pix_x), .pix_y(d_pix_y),
        .line_start(d_line_start), .frame_start(d_frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .SYNC_POL(S_POL), .CW(CW)
    ) dut_s (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .h_sync(s_h_sync), .v_sync(s_v_sync), .video_on(s_video_on),
        .pix_x(s_pix_x), .pix_y(s_pix_y),
        .line_start(s_line_start), .frame_start(s_frame_start)
    );

    // Clock: 100 MHz.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic logic [OW-1:0] mk(input int h, input int v, input bit ls, input bit fs,
                                         input int ha, input int hf, input int hs,
                                         input int va, input int vf, input int vs,
                                         input bit pol, input bit rst);
        bit hs_a, vs_a, von;
        if (rst) return {~pol, ~pol, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
        hs_a = (h >= ha + hf) && (h <= ha + hf + hs - 1);
        vs_a = (v >= va + vf) && (v <= va + vf + vs - 1);
        von  = (h < ha) && (v < va);
        return {hs_a ? pol : ~pol, vs_a ? pol : ~pol, von, ls, fs, 10'(h), 10'(v)};
    endfunction

    task automatic adv(inout int h, inout int v, input int ht, input int vt);
        if (h == ht - 1) begin
            h = 0;
            v = (v == vt - 1) ? 0 : v + 1;
        end else begin
            h = h + 1;
        end
    endtask

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clk: drive pix_en at negedge, push model expectation, compare after posedge.
    task automatic step(input bit en);
        logic [2*OW-1:0] e;
        @(negedge clk);
        pix_en = en;
        if (!reset) begin
            dh = H_TOTAL - 1; dv = V_TOTAL - 1;
            sh = S_HT - 1;    sv = S_VT - 1;
            d_exp = mk(0, 0, 0, 0, H_ACTIVE, H_FP, H_SYNC, V_ACTIVE, V_FP, V_SYNC, 1'b0, 1'b1);
            s_exp = mk(0, 0, 0, 0, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, S_POL, 1'b1);
        end else if (en) begin
            adv(dh, dv, H_TOTAL, V_TOTAL);
            adv(sh, sv, S_HT, S_VT);
            d_exp = mk(dh, dv, dh == 0, (dh == 0) && (dv == 0),
                       H_ACTIVE, H_FP, H_SYNC, V_ACTIVE, V_FP, V_SYNC, 1'b0, 1'b0);
            s_exp = mk(sh, sv, sh == 0, (sh == 0) && (sv == 0),
                       S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, S_POL, 1'b0);
        end else begin
            d_exp[21:20] = 2'b00;
            s_exp[21:20] = 2'b00;
        end
        exp_q.push_back({d_exp, s_exp});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        d_obs = {d_h_sync, d_v_sync, d_video_on, d_line_start, d_frame_start, d_pix_x, d_pix_y};
        s_obs = {s_h_sync, s_v_sync, s_video_on, s_line_start, s_frame_start, s_pix_x, s_pix_y};
        check("dflt_cycle", d_obs, e[2*OW-1:OW]);
        check("small_cycle", s_obs, e[OW-1:0]);
    endtask

    initial begin
        int hs_cnt, von_cnt, period, vs_cnt;
        bit found;
        reset = 1'b0;
        pix_en = 1'b0;

        // Reset held low with pix_en toggling: everything parked.
        for (int i = 0; i < 5; i++) step(bit'(i % 2));
        check("reset_dflt", d_obs, {1'b1, 1'b1, 23'd0});
        check("reset_small", s_obs, {1'b0, 1'b0, 23'd0});

        // Release between edges; first pix_en lands on (0,0) with both strobes.
        reset = 1'b1;
        step(1'b1);
        check("first_px_dflt", d_obs, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'd0});
        check("first_px_small", s_obs, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 20'd0});
        step(1'b0);
        check("strobe_one_clk", {23'd0, d_line_start, d_frame_start}, 25'd0);

        // One full line with pix_en every 4th clk.
        hs_cnt = 0;
        von_cnt = 0;
        step(1'b0); step(1'b0);
        for (int i = 0; i < 800; i++) begin
            step(1'b1);
            if (d_obs[24] == 1'b0) hs_cnt++;
            if (d_obs[22]) von_cnt++;
            step(1'b0); step(1'b0); step(1'b0);
        end
        check("hsync_len", 25'(hs_cnt), 25'(H_SYNC));
        check("video_on_len", 25'(von_cnt), 25'(H_ACTIVE));
        check("line_wrap_xy", {5'd0, d_pix_x, d_pix_y}, {5'd0, 10'd0, 10'd1});

        // pix_en every clk up to x=300, then freeze for 50 clk.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(1'b1);
            if (d_pix_x == 10'd300) found = 1'b1;
        end
        check("reach_x300", 25'(found), 25'd1);
        for (int i = 0; i < 50; i++) step(1'b0);
        check("freeze_x300", d_obs,
              mk(300, 1, 0, 0, H_ACTIVE, H_FP, H_SYNC, V_ACTIVE, V_FP, V_SYNC, 1'b0, 1'b0));

        // Small instance: frame_start period and v_sync width, pix_en every clk.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b1);
            if (s_obs[20]) found = 1'b1;
        end
        check("small_fs_seen", 25'(found), 25'd1);
        found = 1'b0;
        period = 0;
        vs_cnt = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (s_obs[23] == S_POL) vs_cnt++;
            step(1'b1);
            period++;
            if (s_obs[20]) found = 1'b1;
        end
        check("small_fs_period", 25'(period), 25'(S_HT * S_VT));
        check("small_vsync_len", 25'(vs_cnt), 25'(S_HT * S_VS));

        // Run to a point where both syncs of the small instance and h_sync of the
        // full instance are active, then assert reset between clock edges.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step(1'b1);
            if (d_obs[24] == 1'b0 && s_obs[24] == S_POL && s_obs[23] == S_POL) found = 1'b1;
        end
        check("sync_point_found", 25'(found), 25'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_dflt_sync", {23'd0, d_h_sync, d_v_sync}, 25'd3);
        check("async_rst_small_sync", {23'd0, s_h_sync, s_v_sync}, 25'd0);
        check("async_rst_video_on", {23'd0, d_video_on, s_video_on}, 25'd0);
        for (int i = 0; i < 3; i++) step(1'b1);
        reset = 1'b1;
        step(1'b1);
        check("restart_dflt", d_obs, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'd0});
        check("restart_small", s_obs, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 20'd0});
        for (int i = 0; i < 40; i++) step(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
